board_state_uart_tx: RTL and testbench
======================================

Name: board_state_uart_tx

Overview:
Transmit side of the board-state link. Snapshots the 400-bit packed cell-state bus produced by the game top level (4 bits per cell, 100 cells) and serialises it as a framed UART byte stream for an off-chip display or host.
Sits between the game top level and the board's UART TX pin. Driven by a single request pulse and reports busy/done status.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range 2..65535
SYNC_BYTE, 8'hA5, first byte of every frame

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
cell_state_flat  input  400  packed cell states; cell i occupies bits [i*4+3:i*4]
send_req  input  1  single-cycle request to transmit one frame
tx  output  1  UART serial output, 8N1, LSB first, idle high
busy  output  1  high while a frame is in progress
done  output  1  single-cycle pulse when the last stop bit of a frame completes

Behaviour:
- Reset is synchronous and active-high; all state changes occur on the rising edge of clk. After reset: tx=1, busy=0, done=0, FSM in IDLE, all counters 0.
- Frame format: byte 0 = SYNC_BYTE; bytes 1..50 = payload; byte 51 = checksum (when the optional feature is enabled).
  - Payload byte k (1..50) = {cell[2k-1], cell[2k-2]}: even cell in the low nibble, odd cell in the high nibble.
- Each byte is sent as 1 start bit (0), 8 data bits LSB first, then 1 stop bit (1). Every bit is held exactly CLKS_PER_BIT cycles. There is no gap between bytes.
- Request accept: send_req=1 while the FSM is in IDLE.
  - On that edge, cell_state_flat is captured into a 400-bit snapshot register, busy goes to 1, and tx goes to 0 (start bit of byte 0).
  - Later changes on cell_state_flat do not affect the frame in progress.
- send_req while busy=1 is ignored. It is not queued.
- FSM states: IDLE -> START -> DATA (8 bits) -> STOP.
  - From STOP: go to START if more bytes remain; otherwise go to IDLE, assert done for 1 cycle and drop busy.
- Byte index counter: 6 bits, 0..51 (0..50 without checksum). The bit counter is 3 bits. The baud counter counts 0..CLKS_PER_BIT-1 and clears at every bit boundary.
- Frame length: 52*10*CLKS_PER_BIT cycles from the accept edge to the edge that asserts done (51*10*CLKS_PER_BIT without checksum).
- done and busy=0 take effect on the same edge. A send_req in the done cycle is accepted, so back-to-back frames have no idle bit between them.
- Reset mid-frame: on the next edge tx=1 and busy=0, the frame is abandoned, and no done pulse is issued.
- A simultaneous reset and send_req resolves to reset.

Optional Feature:
BOARD_TX_CHECKSUM_EN
- Defined: byte 51 = XOR of payload bytes 1..50. SYNC_BYTE is not included. The frame is 52 bytes.
- Undefined: no checksum byte; the frame ends after byte 50 (51 bytes). The byte counter's terminal value changes accordingly, and no checksum register is synthesised.

Test Plan:
- CLKS_PER_BIT=4, all cells 0, pulse send_req -> the line decodes to A5 followed by 50x 00, then checksum 00. done pulses exactly 2080 cycles after the accept edge (1 cycle wide). busy is high for the whole interval.
- cell0=4'h3, cell1=4'h2, cell98=4'hF, cell99=4'h1, others 0 -> byte1=0x23, byte50=0x1F, checksum=0x3C. Each bit holds for exactly 4 cycles, and the start/stop bits are correct.
- Change cell_state_flat to all 4'h5 one cycle after accept -> the transmitted payload still matches the pre-change snapshot. A second send_req mid-frame produces no effect.
- Assert send_req in the done cycle -> the second frame's start bit begins on the next edge, and tx never returns high between frames.
- Assert reset during byte 10, data bit 3 -> the next edge gives tx=1, busy=0, no done pulse. A new send_req then sends a complete frame starting with A5.
- Build without BOARD_TX_CHECKSUM_EN, CLKS_PER_BIT=4 -> 51 bytes are sent and done arrives 2040 cycles after accept.

Source files
------------

// File: rtl/board_state_uart_tx.sv
// Board-state UART transmitter: snapshots the 100-cell board, sends it as an 8N1 framed byte stream.
// Define BOARD_TX_CHECKSUM_EN to append an XOR checksum byte of the payload.
module board_state_uart_tx #(
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [399:0] cell_state_flat,
    input  logic         send_req,
    output logic         tx,
    output logic         busy,
    output logic         done
);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST    = BW'(CLKS_PER_BIT - 1);
    localparam logic [5:0]    PAYLOAD_LAST = 6'd50;
`ifdef BOARD_TX_CHECKSUM_EN
    localparam logic [5:0]    LAST_BYTE    = 6'd51;
`else
    localparam logic [5:0]    LAST_BYTE    = 6'd50;
`endif

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, next_state;
    logic [BW-1:0]   baud_cnt;
    logic [2:0]      bit_cnt;
    logic [5:0]      byte_idx;
    logic [399:0]    snap;
    logic [7:0]      cur_byte;
    logic            bit_end;
    logic            accept;
    logic            last_stop;
`ifdef BOARD_TX_CHECKSUM_EN
    logic [7:0]      csum;
`endif

    assign bit_end   = (baud_cnt == BAUD_LAST);
    assign accept    = (state == IDLE) && send_req;
    assign last_stop = (state == STOP) && bit_end && (byte_idx == LAST_BYTE);

    // The snapshot shifts down one byte per payload byte sent, so the current payload is always snap[7:0].
    always_comb begin
        cur_byte = snap[7:0];
        if (byte_idx == 6'd0)
            cur_byte = SYNC_BYTE;
`ifdef BOARD_TX_CHECKSUM_EN
        if (byte_idx == LAST_BYTE)
            cur_byte = csum;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (send_req)                     next_state = START;
            START: if (bit_end)                      next_state = DATA;
            DATA:  if (bit_end && bit_cnt == 3'd7)   next_state = STOP;
            STOP:  if (bit_end)
                       next_state = (byte_idx == LAST_BYTE) ? IDLE : START;
            default:                                 next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        case (state)
            START:   tx = 1'b0;
            DATA:    tx = cur_byte[bit_cnt];
            default: tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            byte_idx <= '0;
            snap     <= '0;
            done     <= 1'b0;
`ifdef BOARD_TX_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            done <= last_stop;
            if (accept) begin
                snap     <= cell_state_flat;
                baud_cnt <= '0;
                bit_cnt  <= '0;
                byte_idx <= '0;
`ifdef BOARD_TX_CHECKSUM_EN
                csum     <= '0;
`endif
            end else if (state != IDLE) begin
                if (bit_end) begin
                    baud_cnt <= '0;
                    if (state == DATA)
                        bit_cnt <= bit_cnt + 3'd1;
                    if (state == STOP) begin
                        byte_idx <= (byte_idx == LAST_BYTE) ? 6'd0 : byte_idx + 6'd1;
                        if (byte_idx != 6'd0 && byte_idx <= PAYLOAD_LAST) begin
                            snap <= {8'h00, snap[399:8]};
`ifdef BOARD_TX_CHECKSUM_EN
                            csum <= csum ^ snap[7:0];
`endif
                        end
                    end
                end else begin
                    baud_cnt <= baud_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_board_state_uart_tx.sv
// Bench for board_state_uart_tx: a line monitor decodes tx and checks bytes against a scoreboard queue.
module tb_board_state_uart_tx;
    localparam int CPB = 4;
`ifdef BOARD_TX_CHECKSUM_EN
    localparam int NBYTES = 52;
`else
    localparam int NBYTES = 51;
`endif
    localparam int FRAME = NBYTES * 10 * CPB;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [399:0] cell_state_flat = '0;
    logic         send_req = 1'b0;
    logic         tx, busy, done;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [7:0] sb[$];

    board_state_uart_tx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .reset(reset), .cell_state_flat(cell_state_flat),
        .send_req(send_req), .tx(tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Line monitor: collects CPB samples per bit, 10 bits per byte, then checks framing and data.
    int         mon_cnt = 0;
    logic [39:0] samp;
    always @(negedge clk) begin
        logic       ok;
        logic [7:0] rx, exp_b;
        if (reset) begin
            mon_cnt = 0;
        end else if (mon_cnt == 0) begin
            if (tx === 1'b0) begin
                samp[0] = tx;
                mon_cnt = 1;
            end
        end else begin
            samp[mon_cnt] = tx;
            mon_cnt++;
            if (mon_cnt == 40) begin
                ok = 1'b1;
                for (int b = 0; b < 10; b++)
                    for (int s = 1; s < CPB; s++)
                        if (samp[b*CPB+s] !== samp[b*CPB]) ok = 1'b0;
                for (int i = 0; i < 8; i++) rx[i] = samp[(i+1)*CPB];
                total_cnt++;
                if (!ok || samp[0] !== 1'b0 || samp[36] !== 1'b1)
                    $display("FAIL byte_framing: samples=%b required start=0 stop=1 steady %0d-cycle bits", samp, CPB);
                else
                    pass_cnt++;
                total_cnt++;
                if (sb.size() == 0) begin
                    $display("FAIL byte_data: got %02h, required no byte (scoreboard empty)", rx);
                end else begin
                    exp_b = sb.pop_front();
                    if (rx !== exp_b) $display("FAIL byte_data: got %02h, required %02h", rx, exp_b);
                    else pass_cnt++;
                end
                mon_cnt = 0;
            end
        end
    end

    task automatic push_frame(input logic [399:0] c);
        logic [7:0] b, cs;
        cs = 8'h00;
        sb.push_back(8'hA5);
        for (int k = 1; k <= 50; k++) begin
            b = c[(k-1)*8 +: 8];
            sb.push_back(b);
            cs ^= b;
        end
`ifdef BOARD_TX_CHECKSUM_EN
        sb.push_back(cs);
`endif
    endtask

    // Returns after the accept edge + #1.
    task automatic pulse_req();
        @(posedge clk) #1 send_req = 1'b1;
        @(posedge clk) #1 send_req = 1'b0;
    endtask

    // Counts edges since the accept edge until done is seen; cyc=-1 on timeout.
    task automatic wait_done(input int pre, output int cyc, output int busy_low);
        cyc = -1;
        busy_low = 0;
        for (int k = pre + 1; k <= FRAME + 50; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                cyc = k - 1;
                break;
            end
            if (busy !== 1'b1) busy_low++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        total_cnt++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b required 1", tx); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b required 0", done); else pass_cnt++;
    endtask

    task automatic test_zero_frame();
        int cyc, bl;
        cell_state_flat = '0;
        push_frame(cell_state_flat);
        pulse_req();
        @(negedge clk);
        total_cnt++; if (tx !== 1'b0 || busy !== 1'b1)
            $display("FAIL accept_start: tx=%b busy=%b required tx=0 busy=1", tx, busy); else pass_cnt++;
        wait_done(1, cyc, bl);
        total_cnt++; if (cyc !== FRAME) $display("FAIL zero_frame_len: got %0d required %0d", cyc, FRAME); else pass_cnt++;
        total_cnt++; if (bl !== 0) $display("FAIL zero_busy_held: busy low %0d cycles required 0", bl); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL done_busy_low: busy=%b required 0", busy); else pass_cnt++;
        total_cnt++; if (sb.size() !== 0) $display("FAIL zero_bytes_left: %0d required 0", sb.size()); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (done !== 1'b0) $display("FAIL done_width: done=%b required 0", done); else pass_cnt++;
    endtask

    task automatic test_pattern();
        int cyc, bl;
        cell_state_flat = '0;
        cell_state_flat[3:0]     = 4'h3;
        cell_state_flat[7:4]     = 4'h2;
        cell_state_flat[395:392] = 4'hF;
        cell_state_flat[399:396] = 4'h1;
        push_frame(cell_state_flat);
        pulse_req();
        wait_done(0, cyc, bl);
        total_cnt++; if (cyc !== FRAME) $display("FAIL pattern_len: got %0d required %0d", cyc, FRAME); else pass_cnt++;
        total_cnt++; if (sb.size() !== 0) $display("FAIL pattern_bytes_left: %0d required 0", sb.size()); else pass_cnt++;
    endtask

    task automatic test_snapshot();
        int cyc, bl;
        logic [399:0] c;
        for (int i = 0; i < 100; i++) c[i*4 +: 4] = 4'(i % 16);
        cell_state_flat = c;
        push_frame(c);
        pulse_req();
        @(posedge clk) #1;
        for (int i = 0; i < 100; i++) cell_state_flat[i*4 +: 4] = 4'h5;
        repeat (100) @(posedge clk);
        #1 send_req = 1'b1;
        @(posedge clk) #1 send_req = 1'b0;
        wait_done(102, cyc, bl);
        total_cnt++; if (cyc !== FRAME) $display("FAIL snapshot_len: got %0d required %0d", cyc, FRAME); else pass_cnt++;
        total_cnt++; if (bl !== 0) $display("FAIL snapshot_busy_held: busy low %0d cycles", bl); else pass_cnt++;
        repeat (20) @(negedge clk);
        total_cnt++; if (busy !== 1'b0 || tx !== 1'b1)
            $display("FAIL midframe_req_ignored: busy=%b tx=%b required 0/1", busy, tx); else pass_cnt++;
        total_cnt++; if (sb.size() !== 0) $display("FAIL snapshot_bytes_left: %0d required 0", sb.size()); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int cyc, bl;
        cell_state_flat = {50{8'h9C}};
        push_frame(cell_state_flat);
        pulse_req();
        wait_done(0, cyc, bl);
        cell_state_flat = {50{8'h4B}};
        push_frame(cell_state_flat);
        send_req = 1'b1;
        total_cnt++; if (tx !== 1'b1) $display("FAIL b2b_done_tx: got %b required 1", tx); else pass_cnt++;
        @(posedge clk) #1 send_req = 1'b0;
        @(negedge clk);
        total_cnt++; if (tx !== 1'b0 || busy !== 1'b1)
            $display("FAIL b2b_restart: tx=%b busy=%b required 0/1", tx, busy); else pass_cnt++;
        wait_done(1, cyc, bl);
        total_cnt++; if (cyc !== FRAME) $display("FAIL b2b_len: got %0d required %0d", cyc, FRAME); else pass_cnt++;
        total_cnt++; if (sb.size() !== 0) $display("FAIL b2b_bytes_left: %0d required 0", sb.size()); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int cyc, bl, dcount;
        cell_state_flat = {100{4'h7}};
        push_frame(cell_state_flat);
        pulse_req();
        // Byte 10, data bit 3 starts 10*10*CPB + 4*CPB cycles after accept.
        repeat (10*10*CPB + 4*CPB + 1) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk) #1 reset = 1'b0;
        @(negedge clk);
        total_cnt++; if (tx !== 1'b1 || busy !== 1'b0)
            $display("FAIL midreset_state: tx=%b busy=%b required 1/0", tx, busy); else pass_cnt++;
        dcount = 0;
        for (int k = 0; k < 30 * CPB; k++) begin
            if (done === 1'b1) dcount++;
            @(negedge clk);
        end
        total_cnt++; if (dcount !== 0) $display("FAIL midreset_no_done: %0d pulses required 0", dcount); else pass_cnt++;
        sb.delete();
        cell_state_flat = {25{16'h1E3D}};
        push_frame(cell_state_flat);
        pulse_req();
        wait_done(0, cyc, bl);
        total_cnt++; if (cyc !== FRAME) $display("FAIL post_reset_len: got %0d required %0d", cyc, FRAME); else pass_cnt++;
        total_cnt++; if (sb.size() !== 0) $display("FAIL post_reset_bytes_left: %0d required 0", sb.size()); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_zero_frame();
        test_pattern();
        test_snapshot();
        test_back_to_back();
        test_reset_mid();
        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
